// File: rtl/instr_fetch_32.sv
// Instruction fetch stage: credit-limited in-order word reads, small instruction FIFO, redirect flush.
// Optional IFU_PERF_EN adds saturating stall/redirect performance counters.
module instr_fetch_32 #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_nop
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_redirect_cnt
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned PW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     fill_pc_q, fill_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]   occupancy;
    logic            push;
    logic            pop;

    logic [31:0]     data_mem [BUF_DEPTH];
    logic [31:0]     addr_mem [BUF_DEPTH];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        fill_pc_d  = fill_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push       = 1'b0;
        pop        = 1'b0;

        // Credit covers both buffered words and reads still owed by memory, so the FIFO never overflows.
        occupancy  = OW'(inflight_q) + OW'(count_q);
        o_imem_req = (state_q != IDLE) && !i_redirect && (occupancy < OW'(BUF_DEPTH));

        if (i_redirect) begin
            pc_d       = i_redirect_pc & 32'hFFFF_FFFC;
            fill_pc_d  = i_redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // A response landing in the redirect cycle is dropped here, so it is not counted again.
            inflight_d = inflight_q - CW'(i_imem_valid);
            discard_d  = inflight_d;
            state_d    = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            push = i_imem_valid && (discard_q == '0);
            pop  = (count_q != '0) && !i_stall;
            if (i_imem_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                fill_pc_d = fill_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = inflight_q + CW'(o_imem_req) - CW'(i_imem_valid);
            if (o_imem_req) begin
                pc_d = pc_q + 32'd4;
            end
            case (state_q)
                IDLE:    state_d = RUN;
                DRAIN:   if (discard_d == '0) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fill_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fill_pc_q  <= fill_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage has no reset; o_nop masks stale contents because count_q does reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= i_imem_data;
            addr_mem[wr_ptr_q] <= fill_pc_q;
        end
    end

    assign o_imem_addr   = pc_q;
    assign o_nop         = (count_q == '0);
    assign o_instruction = o_nop ? 32'h0 : data_mem[rd_ptr_q];
    assign o_pc          = o_nop ? 32'h0 : addr_mem[rd_ptr_q];

`ifdef IFU_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_redir_d = perf_redir_q;
        if ((state_q != IDLE) && (o_nop || i_stall) && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (i_redirect && (perf_redir_q != 32'hFFFF_FFFF)) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign o_perf_stall_cnt    = perf_stall_q;
    assign o_perf_redirect_cnt = perf_redir_q;
`endif

endmodule

// File: tb/tb_instr_fetch_32.sv
// Self-checking bench for instr_fetch_32: in-order memory model with random latency, epoch-tagged
// reference model of the fetch buffer, a hand-derived vector table and directed corner sequences.
module tb_instr_fetch_32;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        nop;
`ifdef IFU_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_redir;
`endif

    instr_fetch_32 #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_valid  (imem_valid),
        .i_imem_data   (imem_data),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .o_instruction (instruction),
        .o_pc          (pc_out),
        .o_nop         (nop)
`ifdef IFU_PERF_EN
        ,
        .o_perf_stall_cnt    (perf_stall),
        .o_perf_redirect_cnt (perf_redir)
`endif
    );

    always #5 clk = ~clk;

    // Outstanding memory read: address seen by memory, address the model expected, due cycle, flush epoch.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] maddr;
        int          ready;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } fe_t;

    typedef struct {
        logic        stall;
        logic        nop;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    req_t        mem_q[$];
    fe_t         fq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_ready = -1;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          epoch = 0;
    logic        m_idle = 1'b1;
    logic [31:0] mpc = RPC;
    int          m_pstall = 0;
    int          m_predir = 0;

    logic        act_req, act_nop;
    logic [31:0] act_addr, act_pc, act_inst;
    logic        resp_now;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        mem_q.delete();
        last_ready = -1;
        m_idle     = 1'b1;
        mpc        = RPC;
        m_pstall   = 0;
        m_predir   = 0;
    endtask

    // Asserts reset wherever the bench currently is, checks the reset outputs, then releases
    // just after a rising edge so the following sample lands in the IDLE cycle.
    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        imem_valid  = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check("rst_nop", 32'(nop), 32'd1);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_inst", instruction, 32'h0);
        check("rst_pc", pc_out, 32'h0);
`ifdef IFU_PERF_EN
        check("rst_perf_stall", perf_stall, 32'h0);
        check("rst_perf_redir", perf_redir, 32'h0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs and memory response at the falling edge, sample, compare, advance model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic stl);
        logic        e_nop, e_req;
        logic [31:0] e_inst, e_pc, mpc0;
        int          rdy;
        @(negedge clk);
        resp_now    = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        redirect    = redir;
        redirect_pc = rpc;
        stall       = stl;
        imem_valid  = resp_now;
        imem_data   = resp_now ? word_of(mem_q[0].addr) : $urandom;
        #1;
        act_req  = imem_req;
        act_addr = imem_addr;
        act_nop  = nop;
        act_pc   = pc_out;
        act_inst = instruction;

        e_nop  = (fq.size() == 0);
        e_inst = e_nop ? 32'h0 : fq[0].data;
        e_pc   = e_nop ? 32'h0 : fq[0].pc;
        e_req  = !m_idle && !redir && ((mem_q.size() + fq.size()) < DEPTH);
        check("nop", 32'(act_nop), 32'(e_nop));
        check("inst", act_inst, e_inst);
        check("pc", act_pc, e_pc);
        check("req", 32'(act_req), 32'(e_req));
        if (e_req) check("addr", act_addr, mpc);
        check("fifo_bound", 32'(int'(dut.count_q) <= DEPTH), 32'd1);
`ifdef IFU_PERF_EN
        check("perf_stall", perf_stall, 32'(m_pstall));
        check("perf_redir", perf_redir, 32'(m_predir));
        if (!m_idle && (e_nop || stl)) m_pstall++;
        if (redir) m_predir++;
`endif
        mpc0 = mpc;
        if (redir) begin
            fq.delete();
            mpc = rpc & 32'hFFFF_FFFC;
            epoch++;
        end else begin
            if (!e_nop && !stl) void'(fq.pop_front());
            if (resp_now && (mem_q[0].epoch == epoch))
                fq.push_back('{data: word_of(mem_q[0].maddr), pc: mem_q[0].maddr});
            if (e_req) mpc = mpc + 32'd4;
        end
        if (resp_now) void'(mem_q.pop_front());
        if (act_req) begin
            rdy = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (rdy <= last_ready) rdy = last_ready + 1;
            last_ready = rdy;
            mem_q.push_back('{addr: act_addr, maddr: mpc0, ready: rdy, epoch: epoch});
        end
        m_idle = 1'b0;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        int   n_req;
        logic seen;

        // Latency-1 streaming from reset, then a two-cycle stall that fills the credit window.
        vt[0]  = '{stall: 1'b0, nop: 1'b1, pc: 32'h00, req: 1'b0, addr: 32'h00};
        vt[1]  = '{stall: 1'b0, nop: 1'b1, pc: 32'h00, req: 1'b1, addr: 32'h00};
        vt[2]  = '{stall: 1'b0, nop: 1'b1, pc: 32'h00, req: 1'b1, addr: 32'h04};
        vt[3]  = '{stall: 1'b0, nop: 1'b0, pc: 32'h00, req: 1'b1, addr: 32'h08};
        vt[4]  = '{stall: 1'b0, nop: 1'b0, pc: 32'h04, req: 1'b1, addr: 32'h0C};
        vt[5]  = '{stall: 1'b0, nop: 1'b0, pc: 32'h08, req: 1'b1, addr: 32'h10};
        vt[6]  = '{stall: 1'b0, nop: 1'b0, pc: 32'h0C, req: 1'b1, addr: 32'h14};
        vt[7]  = '{stall: 1'b0, nop: 1'b0, pc: 32'h10, req: 1'b1, addr: 32'h18};
        vt[8]  = '{stall: 1'b1, nop: 1'b0, pc: 32'h14, req: 1'b1, addr: 32'h1C};
        vt[9]  = '{stall: 1'b1, nop: 1'b0, pc: 32'h14, req: 1'b1, addr: 32'h20};
        vt[10] = '{stall: 1'b0, nop: 1'b0, pc: 32'h14, req: 1'b0, addr: 32'h00};
        vt[11] = '{stall: 1'b0, nop: 1'b0, pc: 32'h18, req: 1'b1, addr: 32'h24};
        vt[12] = '{stall: 1'b0, nop: 1'b0, pc: 32'h1C, req: 1'b1, addr: 32'h28};

        #2;
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 32'h0, vt[i].stall);
            check($sformatf("vec%0d_nop", i), 32'(act_nop), 32'(vt[i].nop));
            check($sformatf("vec%0d_pc", i), act_pc, vt[i].pc);
            check($sformatf("vec%0d_req", i), 32'(act_req), 32'(vt[i].req));
            if (vt[i].req) check($sformatf("vec%0d_addr", i), act_addr, vt[i].addr);
        end

        // Latency 3 with stall held: credit stops requests at BUF_DEPTH, then resume at 0x10.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (act_req) n_req++;
        end
        check("stall_req_count", 32'(n_req), 32'd4);
        check("stall_hold_pc", act_pc, 32'h0);
        check("stall_hold_nop", 32'(act_nop), 32'd0);
        step(1'b0, 32'h0, 1'b0);
        check("release_first_pc", act_pc, 32'h0);
        seen = act_req;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            seen = act_req;
        end
        check("resume_req_seen", 32'(seen), 32'd1);
        check("resume_addr", act_addr, 32'h10);

        // Redirect to 0x103 with three reads outstanding.
        lat_lo = 6; lat_hi = 6;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0);
        check("redir_req_in_r", 32'(act_req), 32'd0);
        step(1'b0, 32'h0, 1'b0);
        check("redir_nop_r1", 32'(act_nop), 32'd1);
        check("redir_req_r1", 32'(act_req), 32'd1);
        check("redir_addr_r1", act_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            seen = !act_nop;
        end
        check("redir_first_seen", 32'(seen), 32'd1);
        check("redir_first_pc", act_pc, 32'h100);

        // Redirect coinciding with stall and an arriving response.
        lat_lo = 2; lat_hi = 2;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1);
            seen = (mem_q.size() > 0) && (mem_q[0].ready <= cyc) && (fq.size() > 0);
        end
        check("coincide_setup", 32'(seen), 32'd1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("coincide_nop", 32'(act_nop), 32'd1);
        check("coincide_req", 32'(act_req), 32'd1);
        check("coincide_addr", act_addr, 32'h200);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            seen = !act_nop;
        end
        check("coincide_first_pc", act_pc, 32'h200);

        // Reset mid-stream with a full FIFO.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        check("full_before_reset", 32'(int'(dut.count_q)), 32'(DEPTH));
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        check("post_reset_idle_req", 32'(act_req), 32'd0);
        step(1'b0, 32'h0, 1'b0);
        check("post_reset_req", 32'(act_req), 32'd1);
        check("post_reset_addr", act_addr, RPC);

`ifdef IFU_PERF_EN
        lat_lo = 2; lat_hi = 2;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0400, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0800, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check("perf_stall_ge10", 32'(perf_stall >= 32'd10), 32'd1);
        check("perf_redir_eq2", perf_redir, 32'd2);
`endif

        // Randomised traffic: varying latency, stalls, redirects including near the 32-bit wrap.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [31:0] t;
            if ((i % 200) == 0) begin
                lat_lo = int'($urandom_range(3, 1));
                lat_hi = lat_lo + int'($urandom_range(4, 0));
            end
            r = (i > 3) && ($urandom_range(99, 0) < 4);
            t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            step(r, t, $urandom_range(99, 0) < 30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
